// File: rtl/d_ext_pkg.sv
// Shared decode-stage definitions: extension opcode encodings used by both
// the controller and the immediate/target extender.
package d_ext_pkg;

    localparam logic [3:0] EXT_ZERO      = 4'd0;
    localparam logic [3:0] EXT_SIGN      = 4'd1;
    localparam logic [3:0] EXT_LUI       = 4'd2;
    localparam logic [3:0] EXT_SIGN_SL2  = 4'd3;
    localparam logic [3:0] EXT_BR_TARGET = 4'd4;
    localparam logic [3:0] EXT_J_TARGET  = 4'd5;
    localparam logic [3:0] EXT_LINK      = 4'd6;
    localparam logic [3:0] EXT_SHAMT     = 4'd7;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/d_ext_comb.sv
// Combinational core of the extender: pure function of immediates, PC and op.
module d_ext_comb
    import d_ext_pkg::*;
(
    input  logic [15:0] imm16_i,
    input  logic [25:0] imm26_i,
    input  logic [3:0]  extOp_i,
    input  logic [31:0] pc_i,
    output logic [31:0] ext_o
);

    logic [31:0] sext;
    logic [31:0] pc4;

    assign sext = sext16(imm16_i);
    assign pc4  = pc_i + 32'd4;

    // Adds are modulo 2^32; carry-out is intentionally dropped.
    always_comb begin
        ext_o = 32'h0000_0000;
        case (extOp_i)
            EXT_ZERO:      ext_o = {16'h0000, imm16_i};
            EXT_SIGN:      ext_o = sext;
            EXT_LUI:       ext_o = {imm16_i, 16'h0000};
            EXT_SIGN_SL2:  ext_o = sext << 2;
            EXT_BR_TARGET: ext_o = pc4 + (sext << 2);
            EXT_J_TARGET:  ext_o = {pc4[31:28], imm26_i, 2'b00};
            EXT_LINK:      ext_o = pc_i + 32'd8;
            EXT_SHAMT:     ext_o = {27'h0, imm16_i[10:6]};
            default:       ext_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/d_ext.sv
// Decode-stage immediate/target extender with a single output register.
module d_ext
    import d_ext_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [3:0]  extOp,
    input  logic [31:0] pc,
    output logic [31:0] extImm
);

    logic [31:0] extImm_d;
    logic [31:0] extImm_q;

    d_ext_comb u_comb (
        .imm16_i (imm16),
        .imm26_i (imm26),
        .extOp_i (extOp),
        .pc_i    (pc),
        .ext_o   (extImm_d)
    );

    always_ff @(posedge clk) begin
        if (reset) extImm_q <= 32'h0000_0000;
        else       extImm_q <= extImm_d;
    end

    assign extImm = extImm_q;

endmodule

// File: tb/tb_d_ext.sv
// Directed bench for d_ext: expected values queued at drive time, popped after the edge.
module tb_d_ext;

    logic        clk;
    logic        reset;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [3:0]  extOp;
    logic [31:0] pc;
    logic [31:0] extImm;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          n_checks;
    int          n_pass;

    d_ext dut (
        .clk    (clk),
        .reset  (reset),
        .imm16  (imm16),
        .imm26  (imm26),
        .extOp  (extOp),
        .pc     (pc),
        .extImm (extImm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic rst, input logic [3:0] op, input logic [15:0] i16,
                        input logic [25:0] i26, input logic [31:0] p,
                        input logic [31:0] exp, input string tag);
        logic [31:0] e;
        string       t;
        @(negedge clk);
        reset = rst;
        extOp = op;
        imm16 = i16;
        imm26 = i26;
        pc    = p;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_checks++;
        assert (extImm === e) n_pass++;
        else $error("FAIL %s: got %h expected %h", t, extImm, e);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset = 1'b1;
        extOp = 4'd1;
        imm16 = 16'hFFFF;
        imm26 = 26'h0;
        pc    = 32'h0;

        step(1'b1, 4'd1, 16'hFFFF, 26'h0, 32'h0, 32'h0000_0000, "reset_edge1");
        step(1'b1, 4'd1, 16'hFFFF, 26'h0, 32'h0, 32'h0000_0000, "reset_edge2");
        step(1'b0, 4'd1, 16'hFFFF, 26'h0, 32'h0, 32'hFFFF_FFFF, "post_reset_sign");

        step(1'b0, 4'd0, 16'h8001, 26'h155_5555, 32'h1234_5678, 32'h0000_8001, "zero");
        step(1'b0, 4'd1, 16'h8001, 26'h155_5555, 32'h1234_5678, 32'hFFFF_8001, "sign");
        step(1'b0, 4'd2, 16'h8001, 26'h155_5555, 32'h1234_5678, 32'h8001_0000, "lui");
        step(1'b0, 4'd1, 16'h7FFF, 26'h3FF_FFFF, 32'h0,         32'h0000_7FFF, "sign_pos");

        step(1'b0, 4'd3, 16'hFFFF, 26'h0, 32'h0000_3000, 32'hFFFF_FFFC, "sign_sl2");
        step(1'b0, 4'd4, 16'hFFFF, 26'h0, 32'h0000_3000, 32'h0000_3000, "br_back");
        step(1'b0, 4'd4, 16'h0010, 26'h0, 32'h0000_3000, 32'h0000_3044, "br_fwd");

        step(1'b0, 4'd5, 16'hFFFF, 26'h3FF_FFFF, 32'h0000_3008, 32'h0FFF_FFFC, "j_target");
        step(1'b0, 4'd5, 16'hFFFF, 26'h000_0000, 32'h0FFF_FFFC, 32'h1000_0000, "j_region_cross");
        step(1'b0, 4'd6, 16'hABCD, 26'h2AA_AAAA, 32'h0000_3008, 32'h0000_3010, "link");
        step(1'b0, 4'd6, 16'h1234, 26'h0,        32'hFFFF_FFFC, 32'h0000_0004, "link_wrap");
        step(1'b0, 4'd7, 16'h07C0, 26'h3FF_FFFF, 32'hFFFF_FFFF, 32'h0000_001F, "shamt");
        step(1'b0, 4'd7, 16'hF83F, 26'h0,        32'h0,         32'h0000_0000, "shamt_masked");

        for (int op = 8; op < 16; op++) begin
            step(1'b0, op[3:0], 16'($urandom), 26'($urandom), 32'($urandom) | 32'h1,
                 32'h0000_0000, $sformatf("reserved_op%0d", op));
        end

        step(1'b0, 4'd4, 16'h0001, 26'h0, 32'h0000_1000, 32'h0000_1008, "stream_a");
        step(1'b1, 4'd4, 16'h0002, 26'h0, 32'h0000_1004, 32'h0000_0000, "mid_reset");
        step(1'b0, 4'd4, 16'h0003, 26'h0, 32'h0000_1008, 32'h0000_1018, "stream_resume");
        step(1'b0, 4'd4, 16'h8000, 26'h0, 32'h0000_0000, 32'hFFFE_0004, "br_min_offset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
